uart_tx_queue: RTL

Byte queue and launch controller placed between the RS-232 receiver (or any byte producer) and `async_transmitter`. It absorbs single-cycle `data_ready` pulses into a FIFO. It then feeds the transmitter one byte at a time, following its `TxD_busy` handshake, so bursts arriving faster than the serial line can drain are not lost. In the loopback design it replaces the direct `RxD_data_ready`→`TxD_start` wire.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_byte_fifo.sv | 62 ++++++
 rtl/uart_tx_queue.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte width and launch FSM state type for the UART transmit queue
package uart_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_q_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous byte FIFO with show-ahead read data and registered flags
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_nxt;
  logic              r_full;
  logic              r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({wr_en, rd_en})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Flags are computed from the next count so they change on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = r_full;
  assign empty   = r_empty;
endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue and launch controller feeding async_transmitter via TxD_busy
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int  DEPTH        = 16,
  parameter int  BUSY_TIMEOUT = 4,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  input  logic              clr_overflow
);
  localparam int          TW      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  tx_q_state_t       r_state;
  tx_q_state_t       w_state_nxt;
  logic [TW-1:0]     r_to_cnt;
  logic [TW-1:0]     w_to_cnt_nxt;
  logic              w_pop;
  logic              w_wr_accept;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [BYTE_W-1:0] w_head;
  logic              r_tx_start;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_overflow;

  // A full FIFO still takes a write when the launch pops a byte on the same edge.
  assign w_wr_accept = in_valid && (!w_fifo_full || w_pop);

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_accept),
    .wr_data (in_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_to_cnt_nxt = '0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && !tx_busy) begin
          w_state_nxt = LAUNCH;
          w_pop       = 1'b1;
        end
      end
      LAUNCH:    w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        // A transmitter that never acknowledges must not stall the queue forever.
        if (tx_busy)                 w_state_nxt = WAIT_DONE;
        else if (r_to_cnt == TO_LAST) w_state_nxt = IDLE;
        else                          w_to_cnt_nxt = r_to_cnt + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = IDLE;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_to_cnt   <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= w_head;
      if (in_valid && !w_wr_accept) r_overflow <= 1'b1;
      else if (clr_overflow)        r_overflow <= 1'b0;
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign full     = w_fifo_full;
  assign empty    = w_fifo_empty;
  assign overflow = r_overflow;
endmodule
